// File: rtl/sseg_calc_pkg.sv
// Shared glyph constants, operator/error encodings and width helper for the
// seven-segment operand parser.
package sseg_calc_pkg;

    // active-low segments, bit6..0 = a..g
    localparam logic [6:0] seg_0      = 7'b0000001;
    localparam logic [6:0] seg_1      = 7'b1001111;
    localparam logic [6:0] seg_2      = 7'b0010010;
    localparam logic [6:0] seg_3      = 7'b0000110;
    localparam logic [6:0] seg_4      = 7'b1001100;
    localparam logic [6:0] seg_5      = 7'b0100100;
    localparam logic [6:0] seg_6      = 7'b0100000;
    localparam logic [6:0] seg_7      = 7'b0001111;
    localparam logic [6:0] seg_8      = 7'b0000000;
    localparam logic [6:0] seg_9      = 7'b0000100;
    localparam logic [6:0] seg_blank  = 7'b1111111;
    localparam logic [6:0] seg_minus  = 7'b1111110;
    localparam logic [6:0] seg_plus   = 7'b1101100;
    localparam logic [6:0] seg_times  = 7'b1001000;
    localparam logic [6:0] seg_divide = 7'b1011011;

    localparam logic [1:0] oper_add = 2'd0;
    localparam logic [1:0] oper_sub = 2'd1;
    localparam logic [1:0] oper_mul = 2'd2;
    localparam logic [1:0] oper_div = 2'd3;

    localparam logic [1:0] err_none   = 2'd0;
    localparam logic [1:0] err_digit  = 2'd1;
    localparam logic [1:0] err_blank  = 2'd2;
    localparam logic [1:0] err_symbol = 2'd3;

    typedef struct packed {
        logic       is_digit;
        logic       is_blank;
        logic [3:0] digit;
    } glyph_dec_t;

    // smallest width holding 10^ndig - 1
    function automatic int min_width(input int ndig);
        int p;
        p = 1;
        for (int i = 0; i < ndig; i++) p = p * 10;
        return $clog2(p);
    endfunction

endpackage

// File: rtl/sseg_operand_parser_if.sv
// Request/result bundle between glyph capture logic (master) and the parser (slave).
interface sseg_operand_parser_if #(
    parameter int NDIG = 3,
    parameter int W    = 10
);
    logic                start;
    logic [7*NDIG-1:0]   sseg_a;
    logic [7*NDIG-1:0]   sseg_b;
    logic [6:0]          sign_a_seg;
    logic [6:0]          sign_b_seg;
    logic [6:0]          op_seg;
    logic [W-1:0]        num_a;
    logic [W-1:0]        num_b;
    logic                sign_a;
    logic                sign_b;
    logic [1:0]          oper;
    logic                busy;
    logic                valid;
    logic                err;
    logic [1:0]          err_code;

    modport master (
        output start, sseg_a, sseg_b, sign_a_seg, sign_b_seg, op_seg,
        input  num_a, num_b, sign_a, sign_b, oper, busy, valid, err, err_code
    );

    modport slave (
        input  start, sseg_a, sseg_b, sign_a_seg, sign_b_seg, op_seg,
        output num_a, num_b, sign_a, sign_b, oper, busy, valid, err, err_code
    );
endinterface

// File: rtl/sseg_digit_decode.sv
// Combinational decode of one seven-segment glyph into digit/blank flags and value.
module sseg_digit_decode
    import sseg_calc_pkg::*;
(
    input  logic [6:0] glyph,
    output glyph_dec_t dec
);
    always_comb begin
        dec.is_digit = 1'b1;
        dec.is_blank = 1'b0;
        dec.digit    = 4'd0;
        case (glyph)
            seg_0:     dec.digit = 4'd0;
            seg_1:     dec.digit = 4'd1;
            seg_2:     dec.digit = 4'd2;
            seg_3:     dec.digit = 4'd3;
            seg_4:     dec.digit = 4'd4;
            seg_5:     dec.digit = 4'd5;
            seg_6:     dec.digit = 4'd6;
            seg_7:     dec.digit = 4'd7;
            seg_8:     dec.digit = 4'd8;
            seg_9:     dec.digit = 4'd9;
            seg_blank: begin
                dec.is_digit = 1'b0;
                dec.is_blank = 1'b1;
            end
            default:   dec.is_digit = 1'b0;
        endcase
    end
endmodule

// File: rtl/sseg_operand_parser.sv
// Sequential seven-segment operand parser: snapshots two operands on start and
// converts one digit per clock (acc = acc*10 + d) for both lanes in parallel.
//
// state   | meaning
// --------+-----------------------------------------------------------
// st_idle | waiting for start; results and error code held
// st_conv | one digit per clock from msd down to lsd, completes at idx 0
module sseg_operand_parser
    import sseg_calc_pkg::*;
#(
    parameter int NDIG = 3,
    parameter int W    = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sseg_operand_parser_if.slave bus
);
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [0:0] st_idle = 1'b0;
    localparam logic [0:0] st_conv = 1'b1;

    if (NDIG < 1 || NDIG > 6) begin : g_ndig_chk
        $error("sseg_operand_parser: NDIG must be in 1..6");
    end
    if (W < min_width(NDIG)) begin : g_w_chk
        $error("sseg_operand_parser: W too narrow for NDIG digits");
    end

    logic [0:0]        state;
    logic [IW-1:0]     idx;
    logic [7*NDIG-1:0] sa_q, sb_q;
    logic [6:0]        sga_q, sgb_q, op_q;
    logic [W-1:0]      acc_a, acc_b;
    logic              seen_a, seen_b;
    logic              e_dig, e_blk;

    logic [6:0]        glyph_a, glyph_b;
    glyph_dec_t        dec_a, dec_b;
    logic [W+3:0]      prod_a, prod_b;
    logic [W-1:0]      acc_a_nx, acc_b_nx;
    logic              seen_a_nx, seen_b_nx;
    logic              e_dig_nx, e_blk_nx;
    logic              sgn_a_v, sgn_b_v, sym_err;
    logic [1:0]        oper_v;
    logic [1:0]        code_nx;

    assign glyph_a = sa_q[7*int'(idx) +: 7];
    assign glyph_b = sb_q[7*int'(idx) +: 7];

    sseg_digit_decode u_dec_a (.glyph(glyph_a), .dec(dec_a));
    sseg_digit_decode u_dec_b (.glyph(glyph_b), .dec(dec_b));

    assign prod_a = {4'b0, acc_a} * (W+4)'(10);
    assign prod_b = {4'b0, acc_b} * (W+4)'(10);

    // leading blanks are skipped; a blank after any digit is an embedded blank
    always_comb begin
        acc_a_nx  = acc_a;
        acc_b_nx  = acc_b;
        seen_a_nx = seen_a;
        seen_b_nx = seen_b;
        e_dig_nx  = e_dig;
        e_blk_nx  = e_blk;
        if (dec_a.is_digit) begin
            acc_a_nx  = prod_a[W-1:0] + W'(dec_a.digit);
            seen_a_nx = 1'b1;
        end else if (dec_a.is_blank) begin
            e_blk_nx = e_blk_nx | seen_a;
        end else begin
            e_dig_nx = 1'b1;
        end
        if (dec_b.is_digit) begin
            acc_b_nx  = prod_b[W-1:0] + W'(dec_b.digit);
            seen_b_nx = 1'b1;
        end else if (dec_b.is_blank) begin
            e_blk_nx = e_blk_nx | seen_b;
        end else begin
            e_dig_nx = 1'b1;
        end
    end

    always_comb begin
        sgn_a_v = 1'b0;
        sgn_b_v = 1'b0;
        oper_v  = oper_add;
        sym_err = 1'b0;
        case (sga_q)
            seg_blank: sgn_a_v = 1'b0;
            seg_minus: sgn_a_v = 1'b1;
            default:   sym_err = 1'b1;
        endcase
        case (sgb_q)
            seg_blank: sgn_b_v = 1'b0;
            seg_minus: sgn_b_v = 1'b1;
            default:   sym_err = 1'b1;
        endcase
        case (op_q)
            seg_plus:   oper_v = oper_add;
            seg_minus:  oper_v = oper_sub;
            seg_times:  oper_v = oper_mul;
            seg_divide: oper_v = oper_div;
            default:    sym_err = 1'b1;
        endcase
    end

    assign code_nx = e_dig_nx ? err_digit  :
                     e_blk_nx ? err_blank  :
                     sym_err  ? err_symbol : err_none;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= st_idle;
            idx          <= '0;
            sa_q         <= '0;
            sb_q         <= '0;
            sga_q        <= '0;
            sgb_q        <= '0;
            op_q         <= '0;
            acc_a        <= '0;
            acc_b        <= '0;
            seen_a       <= 1'b0;
            seen_b       <= 1'b0;
            e_dig        <= 1'b0;
            e_blk        <= 1'b0;
            bus.num_a    <= '0;
            bus.num_b    <= '0;
            bus.sign_a   <= 1'b0;
            bus.sign_b   <= 1'b0;
            bus.oper     <= 2'd0;
            bus.busy     <= 1'b0;
            bus.valid    <= 1'b0;
            bus.err      <= 1'b0;
            bus.err_code <= err_none;
        end else begin
            bus.valid <= 1'b0;
            case (state)
                st_idle: begin
                    if (bus.start) begin
                        sa_q     <= bus.sseg_a;
                        sb_q     <= bus.sseg_b;
                        sga_q    <= bus.sign_a_seg;
                        sgb_q    <= bus.sign_b_seg;
                        op_q     <= bus.op_seg;
                        idx      <= IW'(NDIG-1);
                        acc_a    <= '0;
                        acc_b    <= '0;
                        seen_a   <= 1'b0;
                        seen_b   <= 1'b0;
                        e_dig    <= 1'b0;
                        e_blk    <= 1'b0;
                        bus.busy <= 1'b1;
                        state    <= st_conv;
                    end
                end
                default: begin
                    acc_a  <= acc_a_nx;
                    acc_b  <= acc_b_nx;
                    seen_a <= seen_a_nx;
                    seen_b <= seen_b_nx;
                    e_dig  <= e_dig_nx;
                    e_blk  <= e_blk_nx;
                    idx    <= idx - IW'(1);
                    if (idx == '0) begin
                        state        <= st_idle;
                        bus.busy     <= 1'b0;
                        bus.valid    <= 1'b1;
                        bus.err      <= (code_nx != err_none);
                        bus.err_code <= code_nx;
                        // an erroneous result leaves the previous operands visible
                        if (code_nx == err_none) begin
                            bus.num_a  <= acc_a_nx;
                            bus.num_b  <= acc_b_nx;
                            bus.sign_a <= sgn_a_v;
                            bus.sign_b <= sgn_b_v;
                            bus.oper   <= oper_v;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sseg_operand_parser.sv
// Randomized self-checking bench for sseg_operand_parser against a symbol-level model.
module tb_sseg_operand_parser;
    localparam int NDIG = 3;
    localparam int W    = 10;

    localparam int SYM_BLANK = 10;
    localparam int SYM_MINUS = 11;
    localparam int SYM_PLUS  = 12;
    localparam int SYM_TIMES = 13;
    localparam int SYM_DIV   = 14;
    localparam int SYM_JUNK  = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    sseg_operand_parser_if #(.NDIG(NDIG), .W(W)) bus ();

    sseg_operand_parser #(.NDIG(NDIG), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int exp_num_a, exp_num_b, exp_sign_a, exp_sign_b, exp_oper, exp_err, exp_code;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input int s);
        case (s)
            0:         return 7'b0000001;
            1:         return 7'b1001111;
            2:         return 7'b0010010;
            3:         return 7'b0000110;
            4:         return 7'b1001100;
            5:         return 7'b0100100;
            6:         return 7'b0100000;
            7:         return 7'b0001111;
            8:         return 7'b0000000;
            9:         return 7'b0000100;
            SYM_BLANK: return 7'b1111111;
            SYM_MINUS: return 7'b1111110;
            SYM_PLUS:  return 7'b1101100;
            SYM_TIMES: return 7'b1001000;
            SYM_DIV:   return 7'b1011011;
            default:   return 7'b0101010;
        endcase
    endfunction

    function automatic logic [7*NDIG-1:0] pack(input int d[NDIG]);
        logic [7*NDIG-1:0] v;
        v = '0;
        for (int i = 0; i < NDIG; i++) v[7*(NDIG-1-i) +: 7] = glyph(d[i]);
        return v;
    endfunction

    // d[0] is the most significant digit
    task automatic operand_value(input int d[NDIG], output int val,
                                 output bit bad_digit, output bit bad_blank);
        bit seen;
        val = 0; seen = 0; bad_digit = 0; bad_blank = 0;
        for (int i = 0; i < NDIG; i++) begin
            if (d[i] <= 9) begin
                val  = val * 10 + d[i];
                seen = 1;
            end else if (d[i] == SYM_BLANK) begin
                if (seen) bad_blank = 1;
            end else begin
                bad_digit = 1;
            end
        end
    endtask

    task automatic model(input int a[NDIG], input int b[NDIG],
                         input int sa, input int sb, input int op);
        int va, vb, s_a, s_b, o;
        bit bda, bba, bdb, bbb, bsym;
        operand_value(a, va, bda, bba);
        operand_value(b, vb, bdb, bbb);
        bsym = 0;
        s_a = (sa == SYM_MINUS) ? 1 : 0;
        s_b = (sb == SYM_MINUS) ? 1 : 0;
        if (sa != SYM_BLANK && sa != SYM_MINUS) bsym = 1;
        if (sb != SYM_BLANK && sb != SYM_MINUS) bsym = 1;
        case (op)
            SYM_PLUS:  o = 0;
            SYM_MINUS: o = 1;
            SYM_TIMES: o = 2;
            SYM_DIV:   o = 3;
            default: begin o = 0; bsym = 1; end
        endcase
        exp_code = (bda || bdb) ? 1 : (bba || bbb) ? 2 : bsym ? 3 : 0;
        exp_err  = (exp_code != 0) ? 1 : 0;
        if (exp_code == 0) begin
            exp_num_a = va; exp_num_b = vb;
            exp_sign_a = s_a; exp_sign_b = s_b; exp_oper = o;
        end
    endtask

    task automatic model_reset();
        exp_num_a = 0; exp_num_b = 0; exp_sign_a = 0; exp_sign_b = 0;
        exp_oper = 0; exp_err = 0; exp_code = 0;
    endtask

    task automatic check_outputs(input string ctx);
        check_val({ctx, ".num_a"},    int'(bus.num_a),    exp_num_a);
        check_val({ctx, ".num_b"},    int'(bus.num_b),    exp_num_b);
        check_val({ctx, ".sign_a"},   int'(bus.sign_a),   exp_sign_a);
        check_val({ctx, ".sign_b"},   int'(bus.sign_b),   exp_sign_b);
        check_val({ctx, ".oper"},     int'(bus.oper),     exp_oper);
        check_val({ctx, ".err"},      int'(bus.err),      exp_err);
        check_val({ctx, ".err_code"}, int'(bus.err_code), exp_code);
    endtask

    // poke: scramble inputs and re-assert start right after the start edge
    task automatic run_conv(input string ctx, input int a[NDIG], input int b[NDIG],
                            input int sa, input int sb, input int op, input bit poke);
        int n, busy_cnt;
        @(negedge clk);
        bus.sseg_a     = pack(a);
        bus.sseg_b     = pack(b);
        bus.sign_a_seg = glyph(sa);
        bus.sign_b_seg = glyph(sb);
        bus.op_seg     = glyph(op);
        bus.start      = 1'b1;
        model(a, b, sa, sb, op);
        @(negedge clk);
        bus.start = 1'b0;
        check_val({ctx, ".busy_at_start"}, int'(bus.busy), 1);
        check_val({ctx, ".valid_early"},   int'(bus.valid), 0);
        if (poke) begin
            bus.sseg_a     = (7*NDIG)'($urandom);
            bus.sseg_b     = (7*NDIG)'($urandom);
            bus.sign_a_seg = 7'($urandom);
            bus.op_seg     = 7'($urandom);
            bus.start      = 1'b1;
        end
        busy_cnt = int'(bus.busy);
        n = 0;
        while (!bus.valid && n < 12) begin
            @(negedge clk);
            bus.start = 1'b0;
            n++;
            if (!bus.valid) busy_cnt += int'(bus.busy);
        end
        check_val({ctx, ".latency"},     n, NDIG);
        check_val({ctx, ".busy_cycles"}, busy_cnt, NDIG);
        check_val({ctx, ".busy_done"},   int'(bus.busy), 0);
        check_outputs(ctx);
        @(negedge clk);
        check_val({ctx, ".valid_pulse"}, int'(bus.valid), 0);
        check_val({ctx, ".err_hold"},    int'(bus.err), exp_err);
    endtask

    function automatic int rand_digit_sym();
        int r;
        r = int'($urandom_range(0, 19));
        if (r < 13) return int'($urandom_range(0, 9));
        if (r < 18) return SYM_BLANK;
        return int'($urandom_range(SYM_MINUS, SYM_JUNK));
    endfunction

    function automatic int rand_sign_sym();
        int r;
        r = int'($urandom_range(0, 15));
        if (r < 7) return SYM_BLANK;
        if (r < 14) return SYM_MINUS;
        return SYM_JUNK;
    endfunction

    function automatic int rand_op_sym();
        int r;
        r = int'($urandom_range(0, 15));
        if (r < 14) return int'($urandom_range(SYM_MINUS, SYM_DIV));
        return (r == 14) ? SYM_BLANK : SYM_JUNK;
    endfunction

    initial begin
        int a[NDIG], b[NDIG];
        bus.start      = 1'b0;
        bus.sseg_a     = '1;
        bus.sseg_b     = '1;
        bus.sign_a_seg = '1;
        bus.sign_b_seg = '1;
        bus.op_seg     = '1;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs("reset");
        check_val("reset.busy",  int'(bus.busy), 0);
        check_val("reset.valid", int'(bus.valid), 0);
        rst_n = 1'b1;

        a = '{1, 2, 3}; b = '{SYM_BLANK, 4, 5};
        run_conv("t1", a, b, SYM_BLANK, SYM_MINUS, SYM_PLUS, 1'b0);
        a = '{9, 9, 9}; b = '{SYM_BLANK, SYM_BLANK, SYM_BLANK};
        run_conv("t2", a, b, SYM_BLANK, SYM_BLANK, SYM_DIV, 1'b0);
        a = '{1, SYM_BLANK, 2}; b = '{0, 0, 1};
        run_conv("t3", a, b, SYM_BLANK, SYM_BLANK, SYM_PLUS, 1'b0);
        a = '{1, SYM_JUNK, 2}; b = '{1, 2, 3};
        run_conv("t4", a, b, SYM_BLANK, SYM_BLANK, SYM_BLANK, 1'b0);
        a = '{4, 5, 6}; b = '{7, 8, 9};
        run_conv("t5", a, b, SYM_MINUS, SYM_BLANK, SYM_TIMES, 1'b1);

        // reset in the middle of a conversion
        @(negedge clk);
        bus.sseg_a = pack('{8, 7, 6});
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("midreset");
        check_val("midreset.busy", int'(bus.busy), 0);
        repeat (2) @(negedge clk);
        check_val("midreset.idle_busy", int'(bus.busy), 0);
        rst_n = 1'b1;
        a = '{3, 0, 7}; b = '{SYM_BLANK, SYM_BLANK, 5};
        run_conv("t6", a, b, SYM_MINUS, SYM_MINUS, SYM_MINUS, 1'b0);

        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < NDIG; i++) begin
                a[i] = rand_digit_sym();
                b[i] = rand_digit_sym();
            end
            run_conv($sformatf("rnd%0d", it), a, b, rand_sign_sym(), rand_sign_sym(),
                     rand_op_sym(), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sseg_operand_parser.md
Name: sseg_operand_parser

Overview:
Sequential, parametrised successor to the calculator's combinational seven-segment-to-binary stage. On a start pulse it snapshots two NDIG-digit seven-segment operands plus sign and operator glyphs, then converts one digit per clock (Horner: acc = acc*10 + d) for both operands in parallel. It validates every glyph and reports the result with a one-cycle valid pulse and an error code. It sits between the keypad/display capture logic and the ALU.

Parameters:
NDIG, 3, digits per operand; range 1..6.
W, 10, operand output width; must be >= ceil(log2(10^NDIG)), elaboration error otherwise.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  request conversion; sampled only in IDLE.
sseg_a  in  7*NDIG  operand A glyphs; most significant digit in the top 7 bits.
sseg_b  in  7*NDIG  operand B glyphs; same layout as sseg_a.
sign_a_seg  in  7  sign glyph for A.
sign_b_seg  in  7  sign glyph for B.
op_seg  in  7  operator glyph.
num_a  out  W  magnitude of A.
num_b  out  W  magnitude of B.
sign_a  out  1  1 = negative.
sign_b  out  1  1 = negative.
oper  out  2  0 = +, 1 = -, 2 = *, 3 = /.
busy  out  1  high while converting.
valid  out  1  one-cycle completion pulse.
err  out  1  valid result is erroneous; qualified by valid.
err_code  out  2  0 = none, 1 = bad digit glyph, 2 = embedded blank, 3 = bad sign/operator glyph.

Behaviour:
- Glyph encoding is active-low, bit6..0 = a..g:
  - Digits: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
  - Symbols: blank=1111111, minus=1111110, plus=1101100, times=1001000, divide=1011011.
- Reset (async, any state): state=IDLE; all outputs 0; accumulators and snapshot registers 0.
- FSM has two states: IDLE and CONV.
- IDLE:
  - On start=1 at edge k: snapshot all glyph inputs, set digit index to NDIG-1, clear both accumulators and the seen-digit flags, go to CONV.
  - busy=1 from edge k.
- CONV:
  - Edges k+1..k+NDIG process the digit at the current index for A and B simultaneously, then decrement the index.
  - Input changes after edge k are ignored; start is ignored while in CONV.
- Per-digit rules:
  - Blank before any digit of that operand (leading blank): acc unchanged.
  - Blank after a digit has been seen: embedded-blank error (code 2).
  - Any non-digit, non-blank glyph: bad-digit error (code 1).
  - An all-blank operand converts to 0 with no error.
- Completion at edge k+NDIG (the last digit processed):
  - State returns to IDLE; busy=0; valid=1 for exactly one cycle.
  - The if no error: num_a, num_b, sign_a, sign_b, oper and err_code=0 update together.
  - If error: err=1 and err_code is set; num/sign/oper keep their previous values.
  - err and err_code hold until the next completion.
- Latency: valid rises NDIG cycles after the start edge. Back-to-back throughput is one conversion per NDIG+1 cycles (start re-sampled in IDLE).
- Sign glyph: blank→0, minus→1, anything else→code 3.
- Operator glyph: one of the four operators, else code 3.
- Error priority: 1 > 2 > 3. Errors are accumulated across digits; the code reports the highest-priority error seen in either operand.
- Arithmetic:
  - Accumulator is W bits; acc*10 is computed at W+4 bits and truncated to W bits.
  - The maximum value 10^NDIG-1 always fits in W bits, so no overflow.

Decomposition:
- Package sseg_calc_pkg holds:
  - glyph constants (digits, blank, minus, plus, times, divide);
  - oper encoding;
  - err_code values;
  - a function giving the minimum W for a given NDIG.
- One combinational sub-module, sseg_digit_decode: 7-bit glyph → {is_digit, is_blank, digit[3:0]}. It is instantiated twice, once per operand lane, on the indexed glyph.

Test Plan:
- NDIG=3, W=10; A={1,2,3}, B={blank,4,5}, signs blank/minus, op=plus, start pulse → valid 3 cycles later: num_a=123, num_b=45, sign_a=0, sign_b=1, oper=0, err=0.
- A={9,9,9}, B=all blank, op=divide → num_a=999, num_b=0, oper=3, err=0.
- A={1,blank,2} → valid with err=1, err_code=2; outputs retain the prior values from the previous test.
- A middle glyph 0101010 plus op_seg=blank → err_code=1 (priority over code 3).
- Start, then change sseg_a and pulse start again on cycle k+1 → result reflects the snapshot at k; the second start is ignored, and busy stays high for 3 cycles.
- Assert rst_n=0 at cycle k+2 of a conversion → all outputs 0 immediately, state IDLE; a new start after release converts correctly.
